// File: rtl/alu_if.sv
// Operand/opcode bus into the ALU and its result/flag outputs.
interface alu_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [3:0]       ALU_Operation;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry_q;
  logic             overflow_q;
  logic             negative_q;
  logic             zero_q;

  modport master (
    output rd1, rd2, ALU_Operation,
    input  out, zero, carry_q, overflow_q, negative_q, zero_q
  );
  modport slave (
    input  rd1, rd2, ALU_Operation,
    output out, zero, carry_q, overflow_q, negative_q, zero_q
  );
endinterface

// File: rtl/alu.sv
// RV32 integer ALU: combinational result/zero plus a one-cycle registered
// copy of the carry/overflow/negative/zero flags.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  n_rst,
  alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             c, v;

  assign shamt = bus.rd2[SHW-1:0];
  assign sum   = {1'b0, bus.rd1} + {1'b0, bus.rd2};
  // Subtract as a + ~b + 1 so the carry-out reads as "no borrow".
  assign diff  = {1'b0, bus.rd1} + {1'b0, ~bus.rd2} + ONE;

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (bus.ALU_Operation)
      4'b0000: res = bus.rd1 & bus.rd2;
      4'b0001: res = bus.rd1 | bus.rd2;
      4'b0010: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (bus.rd1[WIDTH-1] == bus.rd2[WIDTH-1]) &&
              (res[WIDTH-1] != bus.rd1[WIDTH-1]);
      end
      4'b0011: res = bus.rd1 ^ bus.rd2;
      4'b0100: res = bus.rd1 << shamt;
      4'b0101: res = bus.rd1 >> shamt;
      4'b0110: begin
        res = diff[WIDTH-1:0];
        c   = diff[WIDTH];
        v   = (bus.rd1[WIDTH-1] != bus.rd2[WIDTH-1]) &&
              (res[WIDTH-1] != bus.rd1[WIDTH-1]);
      end
      4'b0111: res = WIDTH'($signed(bus.rd1) >>> shamt);
      4'b1000: res = {{(WIDTH-1){1'b0}}, ($signed(bus.rd1) < $signed(bus.rd2))};
      4'b1001: res = {{(WIDTH-1){1'b0}}, (bus.rd1 < bus.rd2)};
      default: res = '0;
    endcase
  end

  assign bus.out  = res;
  assign bus.zero = (res == '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.carry_q    <= 1'b0;
      bus.overflow_q <= 1'b0;
      bus.negative_q <= 1'b0;
      bus.zero_q     <= 1'b0;
    end else begin
      bus.carry_q    <= c;
      bus.overflow_q <= v;
      bus.negative_q <= res[WIDTH-1];
      bus.zero_q     <= (res == '0);
    end
  end
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected result/flags are queued when a vector is
// driven and popped for comparison against the combinational and registered outputs.
module tb_alu;
  logic clk;
  logic n_rst;
  int   pass_cnt;
  int   total_cnt;

  alu_if #(.WIDTH(32)) bus();
  alu #(.WIDTH(32)) dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eo;
    logic        c;
    logic        v;
    logic        n;
  } vec_t;

  vec_t sb[$];

  // Drive one vector after a falling edge and queue what it should produce.
  task automatic drive(input vec_t t);
    @(negedge clk);
    bus.ALU_Operation = t.op;
    bus.rd1 = t.a;
    bus.rd2 = t.b;
    sb.push_back(t);
  endtask

  task automatic test_reset;
    vec_t e;
    logic [3:0] got;
    n_rst = 1'b0;
    bus.ALU_Operation = 4'h0; bus.rd1 = '0; bus.rd2 = '0;
    #1;
    got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
    total_cnt++;
    if (got !== 4'b0000) $display("FAIL reset_init flags got=%b exp=0000", got);
    else pass_cnt++;
    // flags stay clear through edges while reset is held
    drive('{4'h2, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b1});
    @(posedge clk); #1;
    e = sb.pop_front();
    got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
    total_cnt++;
    if (got !== 4'b0000) $display("FAIL reset_held flags got=%b exp=0000", got);
    else pass_cnt++;
    total_cnt++;
    if (bus.out !== e.eo) $display("FAIL reset_held out got=%h exp=%h", bus.out, e.eo);
    else pass_cnt++;
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
    total_cnt++;
    if (got !== {e.c, e.v, e.n, 1'b0}) $display("FAIL reset_release flags got=%b exp=%b", got, {e.c, e.v, e.n, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_arith;
    vec_t tbl[8] = '{
      '{4'h2, 32'd1,          32'd1,          32'd2,          1'b0, 1'b0, 1'b0},
      '{4'h2, 32'd123894,     32'd2479,       32'd126373,     1'b0, 1'b0, 1'b0},
      '{4'h6, 32'd1293,       32'd192,        32'd1101,       1'b1, 1'b0, 1'b0},
      '{4'h6, 32'd143,        32'd1293,       32'hFFFFFB82,   1'b0, 1'b0, 1'b1},
      '{4'h6, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0, 1'b0},
      '{4'h2, 32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b0, 1'b1, 1'b1},
      '{4'h2, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0, 1'b0},
      '{4'h6, 32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b1, 1'b1, 1'b0}
    };
    vec_t e;
    logic [3:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i]);
      e = sb.pop_front();
      #1;
      total_cnt++;
      if (bus.out !== e.eo || bus.zero !== (e.eo == 0))
        $display("FAIL arith_out op=%h a=%h b=%h got=%h/%b exp=%h/%b", e.op, e.a, e.b, bus.out, bus.zero, e.eo, (e.eo == 0));
      else pass_cnt++;
      @(posedge clk); #1;
      got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
      exp = {e.c, e.v, e.n, (e.eo == 0)};
      total_cnt++;
      if (got !== exp) $display("FAIL arith_flags op=%h a=%h b=%h got=%b exp=%b", e.op, e.a, e.b, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_logic_shift;
    vec_t tbl[10] = '{
      '{4'h0, 32'b110011,     32'b100011,     32'd35,         1'b0, 1'b0, 1'b0},
      '{4'h1, 32'b110100,     32'b111001,     32'd61,         1'b0, 1'b0, 1'b0},
      '{4'h3, 32'h0000FF00,   32'h00000FF0,   32'h0000F0F0,   1'b0, 1'b0, 1'b0},
      '{4'h0, 32'h000000F0,   32'h0000000F,   32'd0,          1'b0, 1'b0, 1'b0},
      '{4'h7, 32'h80000000,   32'd4,          32'hF8000000,   1'b0, 1'b0, 1'b1},
      '{4'h5, 32'h80000000,   32'd4,          32'h08000000,   1'b0, 1'b0, 1'b0},
      '{4'h4, 32'd1,          32'd31,         32'h80000000,   1'b0, 1'b0, 1'b1},
      '{4'h4, 32'h12345678,   32'h00000020,   32'h12345678,   1'b0, 1'b0, 1'b0},
      '{4'h5, 32'hF0000000,   32'hFFFFFFE4,   32'h0F000000,   1'b0, 1'b0, 1'b0},
      '{4'h7, 32'h40000000,   32'd30,         32'd1,          1'b0, 1'b0, 1'b0}
    };
    vec_t e;
    logic [3:0] got, exp;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i]);
      e = sb.pop_front();
      #1;
      total_cnt++;
      if (bus.out !== e.eo || bus.zero !== (e.eo == 0))
        $display("FAIL logic_out op=%h a=%h b=%h got=%h/%b exp=%h/%b", e.op, e.a, e.b, bus.out, bus.zero, e.eo, (e.eo == 0));
      else pass_cnt++;
      @(posedge clk); #1;
      got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
      exp = {e.c, e.v, e.n, (e.eo == 0)};
      total_cnt++;
      if (got !== exp) $display("FAIL logic_flags op=%h a=%h b=%h got=%b exp=%b", e.op, e.a, e.b, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_compare;
    vec_t tbl[10] = '{
      '{4'h8, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b0, 1'b0},
      '{4'h9, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0, 1'b0},
      '{4'h8, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 1'b0},
      '{4'h9, 32'd1,          32'hFFFFFFFF,   32'd1,          1'b0, 1'b0, 1'b0},
      '{4'hA, 32'hDEADBEEF,   32'h12345678,   32'd0,          1'b0, 1'b0, 1'b0},
      '{4'hB, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 1'b0},
      '{4'hC, 32'h80000000,   32'd1,          32'd0,          1'b0, 1'b0, 1'b0},
      '{4'hD, 32'h7FFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0, 1'b0},
      '{4'hE, 32'd5,          32'd5,          32'd0,          1'b0, 1'b0, 1'b0},
      '{4'hF, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0, 1'b0}
    };
    vec_t e;
    logic [3:0] got, exp;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i]);
      e = sb.pop_front();
      #1;
      total_cnt++;
      if (bus.out !== e.eo || bus.zero !== (e.eo == 0))
        $display("FAIL cmp_out op=%h a=%h b=%h got=%h/%b exp=%h/%b", e.op, e.a, e.b, bus.out, bus.zero, e.eo, (e.eo == 0));
      else pass_cnt++;
      @(posedge clk); #1;
      got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
      exp = {e.c, e.v, e.n, (e.eo == 0)};
      total_cnt++;
      if (got !== exp) $display("FAIL cmp_flags op=%h a=%h b=%h got=%b exp=%b", e.op, e.a, e.b, got, exp);
      else pass_cnt++;
    end
  endtask

  // Random ADD/SUB/XOR on consecutive cycles; a junk vector is applied
  // first each cycle so only the value present at the edge may be captured.
  task automatic test_back_to_back;
    vec_t t, e;
    logic [3:0] got, exp;
    logic [32:0] wide;
    longint sa, sb2, sr;
    for (int i = 0; i < 24; i++) begin
      t.a = $urandom();
      t.b = (i % 4 == 0) ? t.a : $urandom();
      case (i % 3)
        0:       t.op = 4'h2;
        1:       t.op = 4'h6;
        default: t.op = 4'h3;
      endcase
      sa  = longint'($signed(t.a));
      sb2 = longint'($signed(t.b));
      t.c = 1'b0; t.v = 1'b0;
      if (t.op == 4'h2) begin
        wide = 33'(t.a) + 33'(t.b);
        t.eo = wide[31:0];
        t.c  = wide[32];
        sr   = sa + sb2;
        t.v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end else if (t.op == 4'h6) begin
        t.eo = t.a - t.b;
        t.c  = (t.a >= t.b);
        sr   = sa - sb2;
        t.v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end else begin
        t.eo = t.a ^ t.b;
      end
      t.n = t.eo[31];
      @(negedge clk);
      bus.ALU_Operation = 4'h7; bus.rd1 = 32'h80000000; bus.rd2 = 32'd0;
      #2;
      bus.ALU_Operation = t.op; bus.rd1 = t.a; bus.rd2 = t.b;
      sb.push_back(t);
      e = sb.pop_front();
      #1;
      total_cnt++;
      if (bus.out !== e.eo || bus.zero !== (e.eo == 0))
        $display("FAIL b2b_out op=%h a=%h b=%h got=%h/%b exp=%h/%b", e.op, e.a, e.b, bus.out, bus.zero, e.eo, (e.eo == 0));
      else pass_cnt++;
      @(posedge clk); #1;
      got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
      exp = {e.c, e.v, e.n, (e.eo == 0)};
      total_cnt++;
      if (got !== exp) $display("FAIL b2b_flags op=%h a=%h b=%h got=%b exp=%b", e.op, e.a, e.b, got, exp);
      else pass_cnt++;
    end
  endtask

  // Assert reset between edges with flags set: they clear at once, out holds.
  task automatic test_async_reset;
    vec_t e;
    logic [3:0] got;
    drive('{4'h2, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b1});
    e = sb.pop_front();
    @(posedge clk); #1;
    got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
    total_cnt++;
    if (got !== 4'b0110) $display("FAIL arst_pre flags got=%b exp=0110", got);
    else pass_cnt++;
    #2 n_rst = 1'b0;
    #1;
    got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
    total_cnt++;
    if (got !== 4'b0000) $display("FAIL arst_clear flags got=%b exp=0000", got);
    else pass_cnt++;
    total_cnt++;
    if (bus.out !== e.eo || bus.zero !== 1'b0)
      $display("FAIL arst_out got=%h/%b exp=%h/0", bus.out, bus.zero, e.eo);
    else pass_cnt++;
    @(negedge clk); n_rst = 1'b1;
    #1;
    got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
    total_cnt++;
    if (got !== 4'b0000) $display("FAIL arst_release_pre flags got=%b exp=0000", got);
    else pass_cnt++;
    @(posedge clk); #1;
    got = {bus.carry_q, bus.overflow_q, bus.negative_q, bus.zero_q};
    total_cnt++;
    if (got !== {e.c, e.v, e.n, 1'b0}) $display("FAIL arst_reload flags got=%b exp=%b", got, {e.c, e.v, e.n, 1'b0});
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_arith();
    test_logic_shift();
    test_compare();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the RV32 single-cycle datapath.
- Takes two register-file operands (`rd1`, `rd2`) and a 4-bit operation code from ALU control.
- Produces a combinational result and a combinational zero flag, used for branch decisions.
- Also keeps a registered copy of the status flags (zero, carry, overflow, negative) for use on the following cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (shift amount uses the low log2(WIDTH) bits of `rd2`).

Ports:
- clk  input  1  system clock, rising-edge active
- n_rst  input  1  asynchronous active-low reset
- rd1  input  WIDTH  operand A
- rd2  input  WIDTH  operand B
- ALU_Operation  input  4  operation select
- out  output  WIDTH  combinational result
- zero  output  1  combinational; 1 when out == 0
- carry_q  output  1  registered carry flag
- overflow_q  output  1  registered signed-overflow flag
- negative_q  output  1  registered sign flag (out[WIDTH-1])
- zero_q  output  1  registered copy of zero

Behaviour:
- `out` and `zero` are purely combinational from `rd1`, `rd2` and `ALU_Operation`: zero latency, independent of `clk` and `n_rst`.
- Operation encodings:
  - 0000 AND: rd1 & rd2
  - 0001 OR: rd1 | rd2
  - 0010 ADD: rd1 + rd2, modulo 2^WIDTH
  - 0011 XOR: rd1 ^ rd2
  - 0100 SLL: rd1 << rd2[4:0]
  - 0101 SRL: logical right shift by rd2[4:0]
  - 0110 SUB: rd1 - rd2, modulo 2^WIDTH (two's complement wrap; no saturation)
  - 0111 SRA: arithmetic right shift by rd2[4:0]
  - 1000 SLT: 1 if signed rd1 < rd2, else 0
  - 1001 SLTU: 1 if unsigned rd1 < rd2, else 0
  - 1010–1111: out = 0, so zero = 1
- Shift amount 0 returns `rd1` unchanged; upper bits of `rd2` are ignored for shifts.
- Combinational flag definitions:
  - carry: ADD = carry-out of bit WIDTH-1. SUB = carry-out of rd1 + ~rd2 + 1 (1 means no borrow, i.e. rd1 >= rd2 unsigned). All other ops = 0.
  - overflow: ADD = both operands share a sign and the result sign differs. SUB = operand signs differ and the result sign differs from rd1. All other ops = 0.
  - negative: out[WIDTH-1] for every op.
- Flag register:
  - On each rising `clk` edge, carry_q, overflow_q, negative_q and zero_q load the current combinational flags.
  - No enable; they update every cycle.
- Reset:
  - `n_rst` = 0 asynchronously clears all *_q outputs to 0, immediately and independent of `clk`.
  - They stay 0 while reset is held.
  - After release, the first rising edge loads live flags.
  - Reset never affects `out` or `zero`.
- An operand or opcode change mid-cycle propagates to `out`/`zero` combinationally; only the value present at the rising edge is captured into the flag registers.
- No X propagation from the unused opcode range: the default branch drives 0.

Test Plan:
- ADD 1+1 -> out=2, zero=0. ADD 123894+2479 -> out=126373.
- SUB 1293-192 -> out=1101, carry_q=1 after edge. SUB 143-1293 -> out=0xFFFFFB82, negative_q=1, carry_q=0 after edge. SUB 5-5 -> out=0, zero=1, zero_q=1 after edge.
- AND 0b110011 & 0b100011 -> out=35. OR 0b110100 | 0b111001 -> out=61. XOR 0xFF00 ^ 0x0FF0 -> 0xF0F0.
- ADD 0x7FFFFFFF+1 -> out=0x80000000, overflow_q=1, negative_q=1 after edge. ADD 0xFFFFFFFF+1 -> out=0, zero=1, carry_q=1, overflow_q=0.
- SRA 0x80000000 by 4 -> 0xF8000000. SRL same -> 0x08000000. SLL 1 by 31 -> 0x80000000. SLT -1 vs 1 -> 1. SLTU -1 vs 1 -> 0. Opcode 1111 -> out=0, zero=1.
- With flags set, drive n_rst low between clock edges -> all *_q read 0 before the next edge while `out` is unchanged. Release -> flags reload at the next rising edge.
